// File: rtl/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Two-master (instruction / data) round-robin arbiter in front of one
//   shared, pipelined memory port with in-order responses.
//
//   Ports
//     clk_i, rst_ni                   clock, async active-low reset
//     instr_req_i / instr_addr_i      instruction master request side
//     instr_gnt_o / instr_rvalid_o / instr_rdata_o   instruction returns
//     data_req_i / data_addr_i / data_we_i / data_be_i / data_wdata_i
//                                     data master request side
//     data_gnt_o / data_rvalid_o / data_rdata_o      data returns
//     mem_req_o / mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o
//                                     shared memory request side
//     mem_gnt_i / mem_rvalid_i / mem_rdata_i         shared memory returns
//     err_o                           sticky: response with nothing pending
//
//   A request that is presented but not granted locks the arbiter onto that
//   master until its handshake, so the address bus never changes under a
//   pending request. An owner FIFO (one bit per handshake) steers the
//   in-order responses back to the master that issued them.
module tb_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2   // power of two, >= 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,

  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,

  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,

  output logic                  err_o
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Owner encoding used everywhere: 0 = instruction, 1 = data.
  typedef enum logic [1:0] {
    LOCK_NONE,
    LOCK_INSTR,
    LOCK_DATA
  } lock_e;

  lock_e                      lock_q, lock_d;
  logic                       last_q;          // owner of most recent handshake
  logic [CNT_W-1:0]           count_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] owner_fifo_q;
  logic                       err_q;

  logic any_req;
  logic full;
  logic lock_hold;
  logic owner;
  logic handshake;
  logic push;
  logic pop;
  logic stray;
  logic head_owner;

  // ---------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------
  always_comb begin
    any_req   = instr_req_i | data_req_i;
    full      = (count_q == CNT_W'(MAX_OUTSTANDING));
    mem_req_o = any_req & ~full;
    handshake = mem_req_o & mem_gnt_i;
    push      = handshake;
  end

  // ---------------------------------------------------------------------
  // Lock FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= LOCK_NONE;
    end else begin
      lock_q <= lock_d;
    end
  end

  // ---------------------------------------------------------------------
  // Lock FSM: next state
  // A lock whose owner has withdrawn its request is dropped combinationally
  // (lock_hold = 0), so arbitration resumes in that same cycle; the state
  // then records whatever the fresh arbitration decided.
  // ---------------------------------------------------------------------
  always_comb begin
    lock_d = lock_hold ? lock_q : LOCK_NONE;
    if (mem_req_o) begin
      if (mem_gnt_i) begin
        lock_d = LOCK_NONE;
      end else begin
        lock_d = owner ? LOCK_DATA : LOCK_INSTR;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Lock FSM: outputs (owner selection, grants, request mux)
  // ---------------------------------------------------------------------
  always_comb begin
    lock_hold = ((lock_q == LOCK_INSTR) && instr_req_i) ||
                ((lock_q == LOCK_DATA)  && data_req_i);

    if (lock_hold) begin
      owner = (lock_q == LOCK_DATA);
    end else if (instr_req_i && data_req_i) begin
      owner = ~last_q;
    end else begin
      owner = data_req_i;
    end

    instr_gnt_o = mem_req_o & ~owner & mem_gnt_i;
    data_gnt_o  = mem_req_o &  owner & mem_gnt_i;

    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (any_req) begin
      if (owner) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = '1;
        mem_wdata_o = '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Round-robin history
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b0;
    end else if (handshake) begin
      last_q <= owner;
    end
  end

  // ---------------------------------------------------------------------
  // Response steering
  // ---------------------------------------------------------------------
  always_comb begin
    head_owner     = owner_fifo_q[rd_ptr_q];
    pop            = mem_rvalid_i & (count_q != '0);
    stray          = mem_rvalid_i & (count_q == '0);
    instr_rvalid_o = pop & ~head_owner;
    data_rvalid_o  = pop &  head_owner;
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    err_o          = err_q;
  end

  // ---------------------------------------------------------------------
  // Owner FIFO. Pointers wrap naturally because the depth is a power of
  // two. A push can never meet a full FIFO since mem_req_o is masked by
  // the registered full flag; a pop in a full cycle only frees the slot
  // for the following cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_fifo_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      if (push) begin
        owner_fifo_q[wr_ptr_q] <= owner;
        wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sticky protocol error
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (stray) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// tb_tb_mem_arbiter
//   Directed bench for tb_mem_arbiter. Inputs change 1 time unit after the
//   rising edge; combinational outputs are sampled one further unit later.
module tb_tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  tb_mem_arbiter #(
    .ADDR_WIDTH     (32),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .data_req_i    (data_req_i),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state with no requests
    settle; settle;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_instr_gnt", instr_gnt_o, 0);
    check("rst_data_gnt", data_gnt_o, 0);
    check("rst_instr_rv", instr_rvalid_o, 0);
    check("rst_data_rv", data_rvalid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_addr", mem_addr_o, 0);
    tick; rst_ni = 1'b1;
    tick;

    // Both masters request, memory always grants: data wins the first tie
    instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
    instr_addr_i = 32'h100; data_addr_i = 32'h200;
    data_we_i = 1; data_be_i = 4'h3; data_wdata_i = 32'hDEAD_BEEF;
    settle;
    check("a_data_gnt", data_gnt_o, 1);
    check("a_instr_gnt0", instr_gnt_o, 0);
    check("a_addr_d", mem_addr_o, 32'h200);
    check("a_we_d", mem_we_o, 1);
    check("a_be_d", mem_be_o, 4'h3);
    check("a_wdata_d", mem_wdata_o, 32'hDEAD_BEEF);
    tick; settle;
    check("a_instr_gnt", instr_gnt_o, 1);
    check("a_data_gnt0", data_gnt_o, 0);
    check("a_addr_i", mem_addr_o, 32'h100);
    check("a_we_i", mem_we_o, 0);
    check("a_be_i", mem_be_o, 4'hF);
    check("a_wdata_i", mem_wdata_o, 0);
    tick; settle;
    // Two outstanding: full
    check("a_full_req", mem_req_o, 0);
    check("a_full_ignt", instr_gnt_o, 0);
    check("a_full_dgnt", data_gnt_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'h11; settle;
    check("a_rv_data", data_rvalid_o, 1);
    check("a_rv_instr0", instr_rvalid_o, 0);
    check("a_rdata_i", instr_rdata_o, 32'h11);
    check("a_rdata_d", data_rdata_o, 32'h11);
    check("a_full_pop_req", mem_req_o, 0);
    tick; mem_rvalid_i = 0; settle;
    check("a_req_after_pop", mem_req_o, 1);
    check("a_third_data", data_gnt_o, 1);
    tick;
    instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h22; settle;
    check("a_rv2_instr", instr_rvalid_o, 1);
    check("a_rv2_data0", data_rvalid_o, 0);
    tick; settle;
    check("a_rv3_data", data_rvalid_o, 1);
    tick; mem_rvalid_i = 0;

    // Lock: data stalled three cycles while instr joins
    data_req_i = 1; data_addr_i = 32'h300; data_we_i = 0; data_be_i = 4'hF;
    settle;
    check("b_addr1", mem_addr_o, 32'h300);
    check("b_dgnt1", data_gnt_o, 0);
    tick; instr_req_i = 1; settle;
    check("b_addr2", mem_addr_o, 32'h300);
    check("b_ignt2", instr_gnt_o, 0);
    tick; settle;
    check("b_addr3", mem_addr_o, 32'h300);
    tick; mem_gnt_i = 1; settle;
    check("b_dgnt4", data_gnt_o, 1);
    check("b_ignt4", instr_gnt_o, 0);
    tick; settle;
    check("b_ignt5", instr_gnt_o, 1);
    check("b_addr5", mem_addr_o, 32'h100);
    tick; instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; settle;
    check("b_addr_idle", mem_addr_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'h33; settle;
    check("b_rv_data", data_rvalid_o, 1);
    tick; settle;
    check("b_rv_instr", instr_rvalid_o, 1);
    tick; mem_rvalid_i = 0;

    // In-order response routing
    instr_req_i = 1; mem_gnt_i = 1; settle;
    check("c_ignt", instr_gnt_o, 1);
    tick; instr_req_i = 0; data_req_i = 1; settle;
    check("c_dgnt", data_gnt_o, 1);
    tick; data_req_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA5555; settle;
    check("c_rv_instr", instr_rvalid_o, 1);
    check("c_rv_data0", data_rvalid_o, 0);
    check("c_rdata_i", instr_rdata_o, 32'hAAAA5555);
    tick; mem_rdata_i = 32'h12345678; settle;
    check("c_rv_data", data_rvalid_o, 1);
    check("c_rv_instr0", instr_rvalid_o, 0);
    check("c_rdata_d", data_rdata_o, 32'h12345678);
    tick; mem_rvalid_i = 0;

    // Locked owner withdraws: arbitration resumes in the same cycle
    instr_req_i = 1; settle;
    check("d_ignt0", instr_gnt_o, 0);
    check("d_addr_i", mem_addr_o, 32'h100);
    tick; instr_req_i = 0; data_req_i = 1; mem_gnt_i = 1; settle;
    check("d_dgnt", data_gnt_o, 1);
    check("d_ignt_drop", instr_gnt_o, 0);
    check("d_addr_d", mem_addr_o, 32'h300);
    tick; data_req_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h44; settle;
    check("d_rv_data", data_rvalid_o, 1);
    tick; mem_rvalid_i = 0;

    // Stray response with nothing outstanding
    mem_rvalid_i = 1; settle;
    check("e_rv_i0", instr_rvalid_o, 0);
    check("e_rv_d0", data_rvalid_o, 0);
    check("e_err_pre", err_o, 0);
    tick; mem_rvalid_i = 0; settle;
    check("e_err_set", err_o, 1);
    tick; tick; settle;
    check("e_err_sticky", err_o, 1);

    // Reset clears error; reset with one outstanding discards it
    rst_ni = 0; settle;
    check("f_err_async", err_o, 0);
    tick; rst_ni = 1; tick;
    instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; settle;
    check("f_tie_data", data_gnt_o, 1);
    check("f_tie_instr0", instr_gnt_o, 0);
    tick; instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; settle;
    check("f_err_clean", err_o, 0);
    #2 rst_ni = 0; settle;
    check("f_rst_req", mem_req_o, 0);
    check("f_rst_err", err_o, 0);
    tick; rst_ni = 1; tick;
    mem_rvalid_i = 1; settle;
    check("f_stray_d0", data_rvalid_o, 0);
    check("f_stray_i0", instr_rvalid_o, 0);
    tick; mem_rvalid_i = 0; settle;
    check("f_stray_err", err_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
